param_sel_mux: RTL and testbench

// - Parametrised N-channel, WIDTH-bit source selector for the CPU datapath; next generation of the 2:1 operand/address muxes.
// - Adds a registered output with valid/ready handshake, per-channel backpressure and a round-robin arbitration mode.
// - Sits between the operand sources (regfile, immediate, PC/ACC) and ALU/memory-address consumers.

---
 rtl/cpu_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/param_sel_mux.sv | 88 ++++++++
 tb/tb_param_sel_mux.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_mux_pkg.sv
// Shared types for the CPU operand/address source selectors.
package cpu_mux_pkg;

  typedef enum logic {
    MODE_DIRECTED = 1'b0,
    MODE_RR       = 1'b1
  } mux_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr+1 and wraps
// modulo NUM_CH, and the first requester it finds wins.
module rr_arbiter
  import cpu_mux_pkg::*;
#(
  parameter int NUM_CH = 3,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      // Explicit wrap keeps idx inside 0..NUM_CH-1 even for non-power-of-2 NUM_CH.
      if (idx >= LAST) idx = '0;
      else             idx = idx + SEL_W'(1);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/param_sel_mux.sv
// N-channel source selector with a registered valid/ready output stage.
// The source is chosen by a directed select or by round-robin arbitration.
module param_sel_mux
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 3,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  input  logic [NUM_CH*WIDTH-1:0] in_data_i,
  output logic [NUM_CH-1:0]       in_ready_o,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_ch_o,
  input  logic                    out_ready_i,
  output logic                    err_o
);

  localparam int               PAD_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_CH - 1);

  hold_state_e      state, state_nxt;
  mux_mode_e        mode;
  logic [PAD_W-1:0] valid_pad;
  logic [SEL_W-1:0] rr_ptr, rr_idx, grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             rr_valid, sel_ok, grant_valid, load_en, xfer;

  assign mode        = mux_mode_e'(mode_i);
  assign out_valid_o = (state == ST_FULL);
  assign load_en     = !out_valid_o || out_ready_i;

  // Padding to a power of two lets an out-of-range sel_i index safely.
  assign valid_pad = PAD_W'(in_valid_i);
  assign sel_ok    = (sel_i <= LAST);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req       (in_valid_i),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign grant_valid = (mode == MODE_RR) ? rr_valid : (sel_ok && valid_pad[sel_i]);
  assign grant_idx   = (mode == MODE_RR) ? rr_idx : sel_i;
  assign xfer        = rst_n && load_en && grant_valid;

  always_comb begin
    in_ready_o = '0;
    grant_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data    = in_data_i[k*WIDTH +: WIDTH];
        in_ready_o[k] = xfer;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (load_en) state_nxt = xfer ? ST_FULL : ST_EMPTY;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      out_data_o <= '0;
      out_ch_o   <= '0;
      err_o      <= 1'b0;
      rr_ptr     <= LAST;
    end else begin
      state <= state_nxt;
      err_o <= load_en && (mode == MODE_DIRECTED) && !sel_ok;
      if (xfer) begin
        out_data_o <= grant_data;
        out_ch_o   <= grant_idx;
        if (mode == MODE_RR) rr_ptr <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_param_sel_mux.sv
// Self-checking bench for param_sel_mux (WIDTH=4, NUM_CH=3): directed vector
// table, hand sequences for round-robin and reset, then random traffic.
module tb_param_sel_mux;

  localparam int W = 4;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n, mode_i, out_ready_i;
  logic [1:0]   sel_i;
  logic [N-1:0] in_valid_i, in_ready_o;
  logic [N*W-1:0] in_data_i;
  logic         out_valid_o, err_o;
  logic [W-1:0] out_data_o;
  logic [1:0]   out_ch_o;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit       m_valid, m_err;
  int       m_data, m_ch, m_ptr;
  int       m_ready;

  always #5 clk = ~clk;

  param_sel_mux #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .sel_i(sel_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ch_o(out_ch_o),
    .out_ready_i(out_ready_i), .err_o(err_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_data(input logic [N*W-1:0] d, input int k);
    return int'((d >> (k * W)) & ((1 << W) - 1));
  endfunction

  // Drive one cycle, compare ready before the edge and outputs after it.
  task automatic apply(input bit r, input bit m, input int s, input int v,
                       input int d, input bit ordy);
    bit gv, load;
    int g;
    rst_n = r; mode_i = m; sel_i = 2'(s); in_valid_i = N'(v);
    in_data_i = (N*W)'(d); out_ready_i = ordy;
    gv = 0; g = 0;
    if (!m) begin
      gv = (s < N) && v[s];
      g  = s;
    end else begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (!gv && v[c]) begin gv = 1; g = c; end
      end
    end
    load    = !m_valid || ordy;
    m_ready = (r && load && gv) ? (1 << g) : 0;
    #1;
    chk("in_ready", int'(in_ready_o), m_ready);
    @(posedge clk);
    if (!r) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_err = 0; m_ptr = N - 1;
    end else begin
      m_err = load && !m && (s >= N);
      if (load) begin
        m_valid = gv;
        if (gv) begin
          m_data = chan_data(in_data_i, g);
          m_ch   = g;
          if (m) m_ptr = g;
        end
      end
    end
    #1;
    chk("out_valid", int'(out_valid_o), int'(m_valid));
    chk("err", int'(err_o), int'(m_err));
    if (m_valid || !r) begin
      chk("out_data", int'(out_data_o), m_data);
      chk("out_ch", int'(out_ch_o), m_ch);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit rst_n; bit mode; int sel; int valid; int data; bit ordy;
    int e_ready; bit e_valid; int e_data; int e_ch; bit e_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst_n = 0; mode_i = 0; sel_i = 0; in_valid_i = 0; in_data_i = 0; out_ready_i = 0;
    m_valid = 0; m_err = 0; m_data = 0; m_ch = 0; m_ptr = N - 1; m_ready = 0;

    //         rst mode sel valid  data     ordy  ready v data ch err
    vecs[0]  = '{0, 1, 2, 3'b111, 12'hCBA, 1, 3'b000, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 2, 3'b111, 12'hCBA, 1, 3'b000, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 2, 3'b111, 12'hCBA, 1, 3'b100, 1, 4'hC, 2, 0};
    vecs[3]  = '{1, 0, 0, 3'b111, 12'hCBA, 1, 3'b001, 1, 4'hA, 0, 0};
    vecs[4]  = '{1, 0, 1, 3'b111, 12'h321, 0, 3'b000, 1, 4'hA, 0, 0};
    vecs[5]  = '{1, 0, 2, 3'b111, 12'h654, 0, 3'b000, 1, 4'hA, 0, 0};
    vecs[6]  = '{1, 0, 0, 3'b111, 12'h987, 0, 3'b000, 1, 4'hA, 0, 0};
    vecs[7]  = '{1, 0, 1, 3'b111, 12'h987, 1, 3'b010, 1, 4'h8, 1, 0};
    vecs[8]  = '{1, 0, 0, 3'b000, 12'h987, 1, 3'b000, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 3, 3'b111, 12'hCBA, 0, 3'b000, 0, 0, 0, 1};
    vecs[10] = '{1, 0, 3, 3'b111, 12'hCBA, 0, 3'b000, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 0, 3'b000, 12'hCBA, 1, 3'b000, 0, 0, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst_n, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].ordy);
      chk($sformatf("vec%0d_ready", i), m_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_valid", i), int'(out_valid_o), int'(vecs[i].e_valid));
      chk($sformatf("vec%0d_err", i), int'(err_o), int'(vecs[i].e_err));
      if (vecs[i].e_valid || !vecs[i].rst_n) begin
        chk($sformatf("vec%0d_data", i), int'(out_data_o), vecs[i].e_data);
        chk($sformatf("vec%0d_ch", i), int'(out_ch_o), vecs[i].e_ch);
      end
    end

    // Round-robin from reset, all requesting: 0,1,2,0
    apply(0, 1, 0, 3'b000, 0, 1);
    begin
      int exp_seq[4] = '{0, 1, 2, 0};
      for (int i = 0; i < 4; i++) begin
        apply(1, 1, 0, 3'b111, 12'hCBA, 1);
        chk($sformatf("rr_all%0d", i), int'(out_ch_o), exp_seq[i]);
      end
    end
    // Round-robin from reset with ch1 idle: 0,2,0,2
    apply(0, 1, 0, 3'b000, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 0, 3'b101, 12'hCBA, 1);
      chk($sformatf("rr_skip%0d", i), int'(out_ch_o), (i % 2) * 2);
    end

    // Reset while FULL and stalled; pointer must restart so ch0 wins next.
    apply(1, 1, 0, 3'b010, 12'h000, 1);
    chk("mid_rr_ch1", int'(out_ch_o), 1);
    apply(1, 0, 0, 3'b001, 12'h005, 1);
    apply(1, 0, 0, 3'b111, 12'h777, 0);
    chk("mid_hold", int'(out_data_o), 5);
    apply(0, 1, 0, 3'b111, 12'h777, 0);
    chk("mid_rst_valid", int'(out_valid_o), 0);
    apply(1, 1, 0, 3'b111, 12'hCBA, 1);
    chk("mid_rst_first", int'(out_ch_o), 0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 99) >= 3), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 4095)), ($urandom_range(0, 99) < 70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
